// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } ifu_state_e;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage signal bundle: imem request/response, decoder output, redirect.
// master = fetch unit, slave = surrounding memory/decoder/execute.
interface ifu_fetch_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned INST_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [XLEN-1:0]   inst_pc;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              fetch_misalign;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst, inst_pc, fetch_misalign,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst, inst_pc, fetch_misalign,
    output inst_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_inst_buf.sv
// Single-entry output register holding the instruction presented to decode.
module ifu_inst_buf #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [INST_W-1:0] loadInst,
  input  logic [XLEN-1:0]   loadPc,
  input  logic              loadMisalign,
  input  logic              clear,
  input  logic              instReady,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   instPc,
  output logic              instValid,
  output logic              fetchMisalign,
  output logic              consume
);

  assign consume = instValid & instReady;

  // Load a new entry, or drop it when consumed or squashed; payload is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst          <= '0;
      instPc        <= '0;
      instValid     <= 1'b0;
      fetchMisalign <= 1'b0;
    end else if (load) begin
      inst          <= loadInst;
      instPc        <= loadPc;
      instValid     <= 1'b1;
      fetchMisalign <= loadMisalign;
    end else if (clear || consume) begin
      instValid     <= 1'b0;
      fetchMisalign <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM,
// redirect handling with stale-response squash.
// Optional: IFU_MISALIGN_CHECK_EN turns misaligned PCs into a flagged nop.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INST_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);

  ifu_state_e        state;
  logic [XLEN-1:0]   pc;
  logic              misaligned;
  logic              reqFire;
  logic              consume;
  logic              bufLoad;
  logic              bufClear;
  logic [INST_W-1:0] bufInst;
  logic              bufMisalign;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign bus.imem_req_valid = rst & (state == FETCH) & ~misaligned;
  assign bus.imem_req_addr  = pc;
  assign reqFire            = bus.imem_req_valid & bus.imem_req_ready;

  // Decide what the output buffer loads or drops this cycle.
  always_comb begin
    bufLoad     = 1'b0;
    bufClear    = 1'b0;
    bufInst     = bus.imem_resp_data;
    bufMisalign = 1'b0;
    case (state)
      FETCH: if (!bus.redirect_valid && misaligned) begin
        bufLoad     = 1'b1;
        bufInst     = INST_W'(INST_NOP);
        bufMisalign = 1'b1;
      end
      WAIT:  bufLoad  = !bus.redirect_valid && bus.imem_resp_valid;
      HOLD:  bufClear = bus.redirect_valid;
      default: ;
    endcase
  end

  // Fetch FSM and PC; redirect overrides every other event in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (bus.redirect_valid) begin
            pc <= bus.redirect_pc;
            // a request accepted with the old pc still owes a response
            if (reqFire) state <= DRAIN;
          end else if (misaligned) begin
            state <= HOLD;
          end else if (reqFire) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            state <= bus.imem_resp_valid ? FETCH : DRAIN;
          end else if (bus.imem_resp_valid) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            state <= FETCH;
          end else if (consume) begin
            pc    <= pc + XLEN'(4);
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (bus.redirect_valid) pc <= bus.redirect_pc;
          if (bus.imem_resp_valid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  ifu_inst_buf #(
    .XLEN   (XLEN),
    .INST_W (INST_W)
  ) u_buf (
    .clk           (clk),
    .rst           (rst),
    .load          (bufLoad),
    .loadInst      (bufInst),
    .loadPc        (pc),
    .loadMisalign  (bufMisalign),
    .clear         (bufClear),
    .instReady     (bus.inst_ready),
    .inst          (bus.inst),
    .instPc        (bus.inst_pc),
    .instValid     (bus.inst_valid),
    .fetchMisalign (bus.fetch_misalign),
    .consume       (consume)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a latency-programmable imem model and
// scoreboards for expected request addresses and delivered instructions.
module tb_ifu_fetch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_if #(.XLEN(64), .INST_W(32)) bus ();

  ifu_fetch #(
    .XLEN     (64),
    .INST_W   (32),
    .RESET_PC (64'h0000_0000_8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned passCnt = 0;
  int unsigned totalCnt = 0;
  int unsigned failCnt = 0;

  logic [63:0] expAddrQ[$];
  logic [63:0] expPcQ[$];
  logic [31:0] expInstQ[$];

  int          memLat = 1;
  int          memCnt = 0;
  bit          memPend = 1'b0;
  logic [63:0] memAddr = '0;

  function automatic logic [31:0] memData(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectReq(input logic [63:0] a);
    expAddrQ.push_back(a);
  endtask

  task automatic expectInst(input logic [63:0] p, input logic [31:0] i);
    expPcQ.push_back(p);
    expInstQ.push_back(i);
  endtask

  task automatic expectFetch(input logic [63:0] a);
    expectReq(a);
    expectInst(a, memData(a));
  endtask

  // One clock: score pre-edge handshakes, then advance the memory model.
  task automatic step();
    bit          reqFire;
    bit          consume;
    bit          respFire;
    logic [63:0] obsAddr;
    @(negedge clk);
    reqFire  = bus.imem_req_valid && bus.imem_req_ready;
    consume  = bus.inst_valid && bus.inst_ready;
    respFire = bus.imem_resp_valid;
    obsAddr  = bus.imem_req_addr;
    if (reqFire) begin
      chk("req_expected", 64'(expAddrQ.size() != 0), 64'd1);
      if (expAddrQ.size() != 0) chk("req_addr", obsAddr, expAddrQ.pop_front());
    end
    if (consume) begin
      chk("inst_expected", 64'(expPcQ.size() != 0), 64'd1);
      if (expPcQ.size() != 0) begin
        chk("inst_pc", bus.inst_pc, expPcQ.pop_front());
        chk("inst", 64'(bus.inst), 64'(expInstQ.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    if (respFire) begin
      memPend = 1'b0;
      bus.imem_resp_valid = 1'b0;
    end
    if (reqFire) begin
      memPend = 1'b1;
      memCnt  = memLat;
      memAddr = obsAddr;
    end
    if (memPend) begin
      memCnt--;
      if (memCnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = memData(memAddr);
      end
    end
  endtask

  initial begin
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.inst_ready      = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_inst", 64'(bus.inst), 64'd0);
    chk("rst_inst_pc", bus.inst_pc, 64'd0);
    chk("rst_misalign", 64'(bus.fetch_misalign), 64'd0);
    rst = 1'b1;

    // Streaming fetch, 1-cycle memory, decoder always ready
    expectFetch(64'h8000_0000);
    expectFetch(64'h8000_0004);
    expectFetch(64'h8000_0008);
    step();
    chk("lat_valid_n1", 64'(bus.inst_valid), 64'd0);
    step();
    chk("lat_valid_n2", 64'(bus.inst_valid), 64'd1);
    repeat (7) step();
    chk("stream_addr_q", 64'(expAddrQ.size()), 64'd0);
    chk("stream_inst_q", 64'(expPcQ.size()), 64'd0);

    // Decoder stall in HOLD
    bus.inst_ready = 1'b0;
    expectReq(64'h8000_000C);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(bus.inst_valid), 64'd1);
      chk("stall_pc", bus.inst_pc, 64'h8000_000C);
      chk("stall_inst", 64'(bus.inst), 64'(memData(64'h8000_000C)));
      chk("stall_no_req", 64'(bus.imem_req_valid), 64'd0);
      step();
    end
    expectInst(64'h8000_000C, memData(64'h8000_000C));
    bus.inst_ready = 1'b1;
    step();
    chk("stall_next_addr", bus.imem_req_addr, 64'h8000_0010);

    // Redirect in WAIT; stale response lands 3 cycles later in DRAIN
    memLat = 4;
    expectReq(64'h8000_0010);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0100;
    step();
    bus.redirect_valid = 1'b0;
    memLat = 1;
    chk("drain_no_req0", 64'(bus.imem_req_valid), 64'd0);
    step();
    chk("drain_no_req1", 64'(bus.imem_req_valid), 64'd0);
    step();
    chk("drain_no_req2", 64'(bus.imem_req_valid), 64'd0);
    step();
    chk("drain_no_inst", 64'(bus.inst_valid), 64'd0);
    chk("redir_wait_addr", bus.imem_req_addr, 64'h8000_0100);
    expectFetch(64'h8000_0100);
    repeat (3) step();

    // Redirect together with inst_ready in HOLD
    bus.inst_ready = 1'b0;
    expectReq(64'h8000_0104);
    step();
    step();
    expectInst(64'h8000_0104, memData(64'h8000_0104));
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0200;
    step();
    bus.redirect_valid = 1'b0;
    chk("hold_redir_valid", 64'(bus.inst_valid), 64'd0);
    chk("hold_redir_addr", bus.imem_req_addr, 64'h8000_0200);
    expectFetch(64'h8000_0200);
    repeat (3) step();

    // PC wrap at the top of the address space
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    expectFetch(64'hFFFF_FFFF_FFFF_FFFC);
    expectFetch(64'h0000_0000_0000_0000);
    step();
    step();
    step();
    chk("wrap_addr", bus.imem_req_addr, 64'h0);
    repeat (3) step();

    // Redirect in FETCH while the request is accepted: old pc goes out
    expectReq(64'h4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0300;
    step();
    bus.redirect_valid = 1'b0;
    chk("fetch_redir_drain", 64'(bus.imem_req_valid), 64'd0);
    expectFetch(64'h8000_0300);
    step();
    repeat (3) step();

    // Misaligned redirect target
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0002;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_no_req", 64'(bus.imem_req_valid), 64'd0);
    bus.inst_ready = 1'b0;
    step();
    chk("mis_valid", 64'(bus.inst_valid), 64'd1);
    chk("mis_inst", 64'(bus.inst), 64'h13);
    chk("mis_pc", bus.inst_pc, 64'h8000_0002);
    chk("mis_flag", 64'(bus.fetch_misalign), 64'd1);
    expectInst(64'h8000_0002, 32'h0000_0013);
    bus.inst_ready = 1'b1;
    step();
    chk("mis_flag_clr", 64'(bus.fetch_misalign), 64'd0);
    chk("mis_no_req2", 64'(bus.imem_req_valid), 64'd0);
`else
    chk("mis_req", 64'(bus.imem_req_valid), 64'd1);
    chk("mis_req_addr", bus.imem_req_addr, 64'h8000_0002);
    bus.inst_ready = 1'b0;
    expectReq(64'h8000_0002);
    step();
    step();
    chk("mis_flag_off", 64'(bus.fetch_misalign), 64'd0);
    chk("mis_pc", bus.inst_pc, 64'h8000_0002);
    expectInst(64'h8000_0002, memData(64'h8000_0002));
    bus.inst_ready = 1'b1;
    step();
`endif
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0400;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;

    // Asynchronous reset while a response is outstanding
    memLat = 3;
    expectReq(64'h8000_0400);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("arst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("arst_inst", 64'(bus.inst), 64'd0);
    chk("arst_inst_pc", bus.inst_pc, 64'd0);
    chk("arst_misalign", 64'(bus.fetch_misalign), 64'd0);
    step();
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    step();
    chk("arst_fetch_addr", bus.imem_req_addr, 64'h8000_0000);
    step();
    chk("arst_stale_ign", 64'(bus.inst_valid), 64'd0);
    bus.imem_req_ready = 1'b1;
    memLat = 1;
    expectFetch(64'h8000_0000);
    repeat (3) step();

    chk("final_addr_q", 64'(expAddrQ.size()), 64'd0);
    chk("final_inst_q", 64'(expPcQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage directly upstream of the decoder. It owns the PC register and issues one word-read at a time to instruction memory over a valid/ready request channel. It holds the returned instruction, with its PC, in an output buffer until the decoder accepts it. The execute stage can redirect the PC, for jal/branches, at any time; in-flight stale fetches are squashed.

Parameters:
XLEN, 64, PC and address width
INST_W, 32, instruction width
RESET_PC, 64'h8000_0000, PC value after reset

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, asynchronous, active-low (0 = reset)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  fetch address (= pc)
imem_resp_valid  in  1  read data valid, one pulse per accepted request
imem_resp_data  in  INST_W  fetched instruction
inst_valid  out  1  instruction to decoder valid
inst_ready  in  1  decoder consumes instruction
inst  out  INST_W  instruction to decoder
inst_pc  out  XLEN  PC of inst
redirect_valid  in  1  PC redirect from execute
redirect_pc  in  XLEN  redirect target
fetch_misalign  out  1  inst_pc not 4-byte aligned (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=FETCH, inst=0, inst_pc=0, inst_valid=0, fetch_misalign=0. imem_req_valid is forced to 0 while rst=0.
- Only one outstanding request at any time. Request and response latency are arbitrary, with a response no earlier than the cycle after acceptance.
- States:
  - FETCH: imem_req_valid=1, addr=pc. On req_ready, go to WAIT.
  - WAIT: on resp_valid, capture data into inst, set inst_pc=pc and inst_valid=1, then go to HOLD.
  - HOLD: inst_valid=1, and inst/inst_pc are stable. On inst_ready, set pc=pc+4, inst_valid=0, then go to FETCH.
  - DRAIN: the outstanding response is stale. On resp_valid, discard it (no capture) and go to FETCH.
- Minimum latency: request accepted in cycle N, response in N+1, inst_valid in N+2. Back-to-back instructions therefore take at least 3 cycles each.
- Redirect has priority over every other event in every state. pc takes redirect_pc on the next edge.
  - FETCH without req_ready: stay in FETCH. The request is withdrawn or re-addressed; imem tolerates this.
  - FETCH with req_ready in the same cycle: the request goes out with the old pc; go to DRAIN.
  - WAIT with no resp_valid: go to DRAIN.
  - WAIT with resp_valid in the same cycle: discard the data; go to FETCH.
  - HOLD, including when inst_ready is asserted in the same cycle: inst_valid=0, no +4; go to FETCH.
  - DRAIN: update pc, stay in DRAIN. With resp_valid in the same cycle, go to FETCH.
- pc+4 wraps modulo 2^XLEN; no overflow flag.
- resp_valid in FETCH or HOLD is a protocol violation and is ignored.
- Reset asserted mid-operation: immediate return to the reset values. Any pending memory response after reset release arrives in FETCH and is ignored.

Optional Feature:
IFU_MISALIGN_CHECK_EN
- Defined: in FETCH, if pc[1:0]!=0, no request is issued. Go directly to HOLD with inst=32'h0000_0013 (nop), inst_pc=pc, fetch_misalign=1. fetch_misalign clears when the instruction is consumed or on redirect.
- Undefined: fetch_misalign is tied to 0 and misaligned PCs are fetched as-is.

Decomposition:
- Package ifu_pkg: state enum {FETCH, WAIT, HOLD, DRAIN}; constants INST_NOP=32'h0000_0013 and default RESET_PC.
- Sub-module ifu_inst_buf: a single-entry output register (inst, inst_pc, inst_valid, fetch_misalign) with load, clear and ready handshake. The FSM and PC logic stay in ifu_fetch.

Test Plan:
- Reset release, memory always ready, 1-cycle response, inst_ready=1: imem_req_addr sequence is 8000_0000, 8000_0004, 8000_0008; inst_valid rises 2 cycles after each accept; inst_pc matches each address.
- Decoder stall: hold inst_ready=0 for 5 cycles in HOLD. inst and inst_pc stay stable and no new request is issued; after inst_ready=1, the next address is +4.
- Redirect in WAIT to 8000_0100, with the stale response arriving 3 cycles later. The stale data never appears on inst; the next request address is 8000_0100.
- Redirect and inst_ready in the same HOLD cycle to 8000_0200. The next address is 8000_0200, not pc+4.
- pc=FFFF_FFFF_FFFF_FFFC: after consume, the next address is 0000_0000_0000_0000.
- With IFU_MISALIGN_CHECK_EN, redirect to 8000_0002: no imem request, inst=0000_0013, fetch_misalign=1, inst_pc=8000_0002. Without the macro, a request is issued to 8000_0002 and fetch_misalign stays 0.
